demux_1to4_reg: RTL

DEMUX_1TO4_REG -- requirements
Module: demux_1to4_reg

---
 rtl/demux_1to4_reg.sv | 72 +++++++
 1 files changed

// File: rtl/demux_1to4_reg.sv
// One-to-four registered demultiplexer: each channel owns a one-word holding
// slot with a valid/ready output, plus a saturating delivered-beat counter.
module demux_1to4_reg #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    input  logic [1:0]         cnt_sel,
    output logic [7:0]         cnt_val
);

    // Handshake: a word moves on a rising edge where valid && ready are both
    // high. Valid never looks at ready; in_ready may follow out_ready of the
    // addressed channel, since a draining slot can take a new word in the same cycle.

    logic [WIDTH-1:0] data_q [4];
    logic [7:0]       cnt_q  [4];
    logic [3:0]       full_q;
    logic [3:0]       drain;
    logic [3:0]       load;

    assign in_ready = !full_q[in_sel] || out_ready[in_sel];
    assign drain    = full_q & out_ready;

    always_comb begin
        load = '0;
        if (in_valid && in_ready) begin
            load[in_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= '0;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                // A load wins over a drain, so a same-cycle refill keeps the slot full.
                if (load[k]) begin
                    data_q[k] <= in_data;
                    full_q[k] <= 1'b1;
                end else if (drain[k]) begin
                    full_q[k] <= 1'b0;
                end
                if (drain[k] && cnt_q[k] != 8'hFF) begin
                    cnt_q[k] <= cnt_q[k] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int k = 0; k < 4; k++) begin
            out_data[k*WIDTH +: WIDTH] = data_q[k];
        end
    end

    assign out_valid = full_q;
    assign cnt_val   = cnt_q[cnt_sel];

endmodule
